ds_sample_scheduler: RTL and testbench
======================================

// Module: ds_sample_scheduler
// PURPOSE
//  Feeds input samples to delta_sigma_pw_modulator. Buffers host samples in a small FIFO and presents one
//  sample on u for exactly (osr_cfg+1) modulator pulses (zero-order-hold oversampling).
//  Latches u_rshift only at sample boundaries and reports underflow.
//  Sits between the register/SPI sample interface and the modulator's u/u_rshift/pulse_done ports.
// PARAMETERS
//  IN_BITS          16  sample width (matches modulator IN_BITS)
//  SHIFT_COUNT_BITS 4   width of u_rshift (matches modulator)
//  FIFO_AW          2   FIFO address bits; depth = 2**FIFO_AW
//  OSR_BITS         8   width of hold counter / osr_cfg
// PORTS
//  clk              in   1                clock
//  reset            in   1                asynchronous, active-high reset
//  enable           in   1                1 = run scheduler, 0 = park in IDLE
//  flush            in   1                synchronous FIFO clear (1 cycle)
//  in_data          in   IN_BITS          host sample
//  in_valid         in   1                in_data valid
//  in_ready         out  1                FIFO can accept (= !full)
//  osr_cfg          in   OSR_BITS         pulses per sample minus 1
//  rshift_cfg       in   SHIFT_COUNT_BITS gain shift, applied at next sample load
//  idle_value       in   IN_BITS          u value while IDLE
//  pulse_done       in   1                from modulator; modulator consumes u in this cycle
//  u                out  IN_BITS          registered sample to modulator
//  u_rshift         out  SHIFT_COUNT_BITS registered shift to modulator
//  sample_tick      out  1                1-cycle pulse: new FIFO sample loaded into u
//  underflow        out  1                sticky: sample boundary reached with FIFO empty
//  clear_underflow  in   1                clears underflow
//  fifo_level       out  FIFO_AW+1        entries in FIFO (0..2**FIFO_AW)
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, u=0, u_rshift=0, hold_cnt=0, sample_tick=0, underflow=0, in_ready=1.
//  Push: in_valid & in_ready -> write at wr_ptr; in_ready=!full combinationally; no push when full even if popping.
//  Pop: only by FSM as below; never when empty; no empty-FIFO bypass of a same-cycle push.
//  All state updates on posedge clk; u/u_rshift change only on the edge ending a pulse_done cycle or load event.
//  FSM:
//   IDLE: u<=idle_value each cycle, hold_cnt<=0. enable & !empty -> pop into u, u_rshift<=rshift_cfg,
//         sample_tick=1, -> RUN. enable & empty -> STARVED (no underflow flag).
//   RUN: pulse_done & hold_cnt<osr_cfg -> hold_cnt++. pulse_done & hold_cnt>=osr_cfg (>= so that an osr_cfg
//         lowered mid-period ends it at once) -> hold_cnt<=0; if !empty pop into u,
//         u_rshift<=rshift_cfg, sample_tick=1; else underflow<=1, u holds last sample, -> STARVED.
//   STARVED: u held. pulse_done & !empty -> pop, load u/u_rshift, sample_tick=1, hold_cnt<=0, -> RUN.
//         Load only at pulse_done so sample periods stay pulse-aligned.
//  enable=0 in any state -> IDLE at next edge (overrides pop; u<=idle_value); FIFO contents kept.
//  flush: FIFO pointers/level cleared; a same-cycle push is dropped; a same-cycle pop is
//         suppressed and treated as empty (RUN -> STARVED + underflow).
//  underflow: set has priority over clear_underflow in the same cycle.
//  osr_cfg=0: new sample on every pulse_done. Pointers wrap modulo 2**FIFO_AW; level from ptrs incl. wrap bit.
//  Reset asserted mid-operation: all state returns to reset values immediately (async), FIFO data discarded.
// TESTING
//  osr_cfg=3, push 10,20,30, enable: u=10 after load; u steps 20 after 4th pulse_done, 30 after 8th; 3 sample_ticks.
//  FIFO_AW=2: push 5 with no pops -> 4 accepted, in_ready=0 at level 4; pop one -> in_ready=1 next cycle.
//  Drain FIFO in RUN: at boundary with level 0 -> underflow=1, u holds last value, STARVED;
//   push 7 -> loads at next pulse_done.
//  rshift_cfg changed 2->5 mid-period: u_rshift stays 2 until the boundary pulse_done edge, then 5.
//  enable dropped in RUN with idle_value=16'h8000: u=8000 next cycle, FIFO level unchanged;
//   re-enable reloads next entry.
//  Async reset asserted between clock edges mid-RUN: u=0, level=0, underflow=0 before next edge.

Source files
------------

// File: rtl/ds_sample_scheduler.sv
// ds_sample_scheduler: buffers host samples in a small FIFO and holds each one on u
// for (osr_cfg+1) modulator pulses, latching the gain shift at sample boundaries.
module ds_sample_scheduler #(
    parameter int unsigned IN_BITS          = 16,
    parameter int unsigned SHIFT_COUNT_BITS = 4,
    parameter int unsigned FIFO_AW          = 2,
    parameter int unsigned OSR_BITS         = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        flush,
    input  logic [IN_BITS-1:0]          in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OSR_BITS-1:0]         osr_cfg,
    input  logic [SHIFT_COUNT_BITS-1:0] rshift_cfg,
    input  logic [IN_BITS-1:0]          idle_value,
    input  logic                        pulse_done,
    output logic [IN_BITS-1:0]          u,
    output logic [SHIFT_COUNT_BITS-1:0] u_rshift,
    output logic                        sample_tick,
    output logic                        underflow,
    input  logic                        clear_underflow,
    output logic [FIFO_AW:0]            fifo_level
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned LVL_W = FIFO_AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STARVED = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [IN_BITS-1:0]          r_mem [DEPTH];
    logic [LVL_W-1:0]            r_wr_ptr;
    logic [LVL_W-1:0]            r_rd_ptr;
    logic [IN_BITS-1:0]          r_u;
    logic [SHIFT_COUNT_BITS-1:0] r_u_rshift;
    logic [OSR_BITS-1:0]         r_hold_cnt;
    logic                        r_sample_tick;
    logic                        r_underflow;

    logic [LVL_W-1:0]            w_level;
    logic                        w_full;
    logic                        w_avail;
    logic                        w_push;
    logic                        w_load;
    logic                        w_uf_set;
    logic                        w_u_idle;
    logic [OSR_BITS-1:0]         w_hold_nxt;

    // FIFO occupancy from pointers including the wrap bit; a flush hides any stored entry
    assign w_level  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_level == LVL_W'(DEPTH));
    assign w_avail  = (w_level != '0) && !flush;
    assign w_push   = in_valid && !w_full && !flush;

    assign in_ready    = !w_full;
    assign fifo_level  = w_level;
    assign u           = r_u;
    assign u_rshift    = r_u_rshift;
    assign sample_tick = r_sample_tick;
    assign underflow   = r_underflow;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and datapath control; loads happen only on pulse boundaries once running
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_uf_set    = 1'b0;
        w_u_idle    = 1'b0;
        w_hold_nxt  = r_hold_cnt;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_u_idle    = 1'b1;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_hold_nxt = '0;
                    if (w_avail) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_u_idle    = 1'b1;
                        w_state_nxt = ST_STARVED;
                    end
                end
                ST_RUN: begin
                    if (pulse_done) begin
                        if (r_hold_cnt < osr_cfg) begin
                            w_hold_nxt = r_hold_cnt + OSR_BITS'(1);
                        end else begin
                            w_hold_nxt = '0;
                            if (w_avail) begin
                                w_load = 1'b1;
                            end else begin
                                w_uf_set    = 1'b1;
                                w_state_nxt = ST_STARVED;
                            end
                        end
                    end
                end
                ST_STARVED: begin
                    if (pulse_done && w_avail) begin
                        w_load      = 1'b1;
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= in_data;
    end

    // FIFO pointers; flush wins over same-cycle push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + LVL_W'(1);
            if (w_load) r_rd_ptr <= r_rd_ptr + LVL_W'(1);
        end
    end

    // Output sample, shift, hold counter, tick and sticky underflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_u           <= '0;
            r_u_rshift    <= '0;
            r_hold_cnt    <= '0;
            r_sample_tick <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (w_load) begin
                r_u        <= r_mem[r_rd_ptr[FIFO_AW-1:0]];
                r_u_rshift <= rshift_cfg;
            end else if (w_u_idle) begin
                r_u <= idle_value;
            end
            r_hold_cnt    <= w_hold_nxt;
            r_sample_tick <= w_load;
            if (w_uf_set)             r_underflow <= 1'b1;
            else if (clear_underflow) r_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ds_sample_scheduler.sv
// Directed bench for ds_sample_scheduler: vector table plus hand sequences.
module tb_ds_sample_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        flush;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  osr_cfg;
    logic [3:0]  rshift_cfg;
    logic [15:0] idle_value;
    logic        pulse_done;
    logic [15:0] u;
    logic [3:0]  u_rshift;
    logic        sample_tick;
    logic        underflow;
    logic        clear_underflow;
    logic [2:0]  fifo_level;

    int n_checks = 0;
    int n_fail   = 0;

    ds_sample_scheduler dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .osr_cfg(osr_cfg), .rshift_cfg(rshift_cfg), .idle_value(idle_value),
        .pulse_done(pulse_done), .u(u), .u_rshift(u_rshift),
        .sample_tick(sample_tick), .underflow(underflow),
        .clear_underflow(clear_underflow), .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [15:0] din;
        logic        en;
        logic        pd;
        logic [3:0]  rs;
        logic        clr;
        logic [15:0] eu;
        logic [3:0]  ers;
        logic        etk;
        logic [2:0]  elv;
        logic        euf;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0;
        osr_cfg = 8'd3; rshift_cfg = '0; idle_value = '0; pulse_done = 1'b0;
        clear_underflow = 1'b0;

        //             vld   din     en    pd    rs    clr  | eu      ers   etk   elv   euf
        tbl[0]  = '{1'b1, 16'd10, 1'b0, 1'b0, 4'd0, 1'b0, 16'd0,  4'd0, 1'b0, 3'd1, 1'b0};
        tbl[1]  = '{1'b1, 16'd20, 1'b0, 1'b0, 4'd0, 1'b0, 16'd0,  4'd0, 1'b0, 3'd2, 1'b0};
        tbl[2]  = '{1'b1, 16'd30, 1'b0, 1'b0, 4'd0, 1'b0, 16'd0,  4'd0, 1'b0, 3'd3, 1'b0};
        tbl[3]  = '{1'b0, 16'd0,  1'b1, 1'b0, 4'd2, 1'b0, 16'd10, 4'd2, 1'b1, 3'd2, 1'b0};
        tbl[4]  = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd2, 1'b0, 16'd10, 4'd2, 1'b0, 3'd2, 1'b0};
        tbl[5]  = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd5, 1'b0, 16'd10, 4'd2, 1'b0, 3'd2, 1'b0};
        tbl[6]  = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd5, 1'b0, 16'd10, 4'd2, 1'b0, 3'd2, 1'b0};
        tbl[7]  = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd5, 1'b0, 16'd20, 4'd5, 1'b1, 3'd1, 1'b0};
        tbl[8]  = '{1'b0, 16'd0,  1'b1, 1'b0, 4'd5, 1'b0, 16'd20, 4'd5, 1'b0, 3'd1, 1'b0};
        tbl[9]  = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd5, 1'b0, 16'd20, 4'd5, 1'b0, 3'd1, 1'b0};
        tbl[10] = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd5, 1'b0, 16'd20, 4'd5, 1'b0, 3'd1, 1'b0};
        tbl[11] = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd5, 1'b0, 16'd20, 4'd5, 1'b0, 3'd1, 1'b0};
        tbl[12] = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd5, 1'b0, 16'd30, 4'd5, 1'b1, 3'd0, 1'b0};
        tbl[13] = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd5, 1'b0, 16'd30, 4'd5, 1'b0, 3'd0, 1'b0};
        tbl[14] = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd5, 1'b0, 16'd30, 4'd5, 1'b0, 3'd0, 1'b0};
        tbl[15] = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd5, 1'b0, 16'd30, 4'd5, 1'b0, 3'd0, 1'b0};
        tbl[16] = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd5, 1'b0, 16'd30, 4'd5, 1'b0, 3'd0, 1'b1};
        tbl[17] = '{1'b1, 16'd7,  1'b1, 1'b0, 4'd5, 1'b0, 16'd30, 4'd5, 1'b0, 3'd1, 1'b1};
        tbl[18] = '{1'b0, 16'd0,  1'b1, 1'b1, 4'd5, 1'b0, 16'd7,  4'd5, 1'b1, 3'd0, 1'b1};
        tbl[19] = '{1'b0, 16'd0,  1'b1, 1'b0, 4'd5, 1'b1, 16'd7,  4'd5, 1'b0, 3'd0, 1'b0};

        // Reset state
        #12;
        chk("rst_u", 32'(u), 32'd0);
        chk("rst_rshift", 32'(u_rshift), 32'd0);
        chk("rst_tick", 32'(sample_tick), 32'd0);
        chk("rst_uf", 32'(underflow), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // Zero-order hold with osr_cfg=3, rshift change mid-period, drain to underflow
        for (int i = 0; i < 20; i++) begin
            in_valid = tbl[i].vld; in_data = tbl[i].din; enable = tbl[i].en;
            pulse_done = tbl[i].pd; rshift_cfg = tbl[i].rs; clear_underflow = tbl[i].clr;
            step();
            chk($sformatf("v%0d_u", i), 32'(u), 32'(tbl[i].eu));
            chk($sformatf("v%0d_rshift", i), 32'(u_rshift), 32'(tbl[i].ers));
            chk($sformatf("v%0d_tick", i), 32'(sample_tick), 32'(tbl[i].etk));
            chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'(tbl[i].elv));
            chk($sformatf("v%0d_uf", i), 32'(underflow), 32'(tbl[i].euf));
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(tbl[i].elv != 3'd4));
        end
        in_valid = 1'b0; pulse_done = 1'b0; clear_underflow = 1'b0; enable = 1'b0;

        // Fill to full: 5 pushes, only 4 accepted
        reset = 1'b1; step(); reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1; in_data = 16'(k);
            if (k == 5) chk("full_ready_before", 32'(in_ready), 32'd0);
            step();
            chk($sformatf("fill%0d_level", k), 32'(fifo_level), 32'((k > 4) ? 4 : k));
            chk($sformatf("fill%0d_ready", k), 32'(in_ready), 32'(k < 4));
        end
        in_valid = 1'b0;
        enable = 1'b1; step();
        chk("pop_u", 32'(u), 32'd1);
        chk("pop_tick", 32'(sample_tick), 32'd1);
        chk("pop_level", 32'(fifo_level), 32'd3);
        chk("pop_ready", 32'(in_ready), 32'd1);

        // Disable in RUN drives idle_value and keeps FIFO, re-enable reloads next entry
        idle_value = 16'h8000; enable = 1'b0; step();
        chk("dis_u", 32'(u), 32'h8000);
        chk("dis_level", 32'(fifo_level), 32'd3);
        step();
        chk("dis2_u", 32'(u), 32'h8000);
        chk("dis2_tick", 32'(sample_tick), 32'd0);
        enable = 1'b1; step();
        chk("reen_u", 32'(u), 32'd2);
        chk("reen_tick", 32'(sample_tick), 32'd1);
        chk("reen_level", 32'(fifo_level), 32'd2);

        // Flush on a boundary with osr_cfg=0: treated as empty -> underflow, u held
        osr_cfg = 8'd0; pulse_done = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 16'd99;
        step();
        flush = 1'b0; in_valid = 1'b0; pulse_done = 1'b0;
        chk("flush_level", 32'(fifo_level), 32'd0);
        chk("flush_uf", 32'(underflow), 32'd1);
        chk("flush_u", 32'(u), 32'd2);
        chk("flush_tick", 32'(sample_tick), 32'd0);

        // Starved: no load without pulse_done, then load on pulse_done
        in_valid = 1'b1; in_data = 16'd9; step();
        in_valid = 1'b0;
        chk("starve_u", 32'(u), 32'd2);
        chk("starve_level", 32'(fifo_level), 32'd1);
        pulse_done = 1'b1; step();
        pulse_done = 1'b0;
        chk("starve_load_u", 32'(u), 32'd9);
        chk("starve_load_tick", 32'(sample_tick), 32'd1);

        // osr_cfg=0: a new sample on every pulse_done
        in_valid = 1'b1; in_data = 16'd21; step();
        in_data = 16'd22; step();
        in_valid = 1'b0; pulse_done = 1'b1; step();
        chk("osr0_a_u", 32'(u), 32'd21);
        step();
        chk("osr0_b_u", 32'(u), 32'd22);
        chk("osr0_b_level", 32'(fifo_level), 32'd0);
        pulse_done = 1'b0;
        in_valid = 1'b1; in_data = 16'd5; step();
        in_valid = 1'b0;

        // Asynchronous reset between edges mid-RUN
        #2 reset = 1'b1;
        #1;
        chk("areset_u", 32'(u), 32'd0);
        chk("areset_level", 32'(fifo_level), 32'd0);
        chk("areset_uf", 32'(underflow), 32'd0);
        chk("areset_rshift", 32'(u_rshift), 32'd0);
        chk("areset_ready", 32'(in_ready), 32'd1);
        #1 reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
